stream_width_converter: RTL

//  Parametrised valid/ready stream width converter; replaces fixed s32s16/s16s8 adapters.

---
 rtl/stream_pkg.sv | 29 ++
 rtl/swc_slice_mux.sv | 38 +++
 rtl/stream_width_converter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converter: conversion modes,
// ratio/index-width helpers and the down-converter state encoding.
package stream_pkg;

    localparam int SWC_PASS = 0;
    localparam int SWC_DOWN = 1;
    localparam int SWC_UP   = 2;

    typedef enum logic {
        SWC_IDLE  = 1'b0,
        SWC_SHIFT = 1'b1
    } swc_state_t;

    function automatic int swc_ratio(input int in_w, input int out_w);
        return (in_w > out_w) ? (in_w / out_w) : (out_w / in_w);
    endfunction

    // A 1:1 ratio still needs a 1-bit index so every vector has a legal width.
    function automatic int swc_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int swc_mode(input int in_w, input int out_w);
        if (in_w == out_w)
            return SWC_PASS;
        return (in_w > out_w) ? SWC_DOWN : SWC_UP;
    endfunction

endpackage

// File: rtl/swc_slice_mux.sv
// Slice select / slice replace over a wide word, indexed in transfer order.
// With MSB_FIRST the transfer index 0 maps to the most-significant slice.
module swc_slice_mux #(
    parameter int WIDE_W    = 32,
    parameter int NARROW_W  = 16,
    parameter int MSB_FIRST = 1,
    parameter int IDX_W     = 1
) (
    input  logic [WIDE_W-1:0]   wide_in,
    input  logic [NARROW_W-1:0] narrow_in,
    input  logic [IDX_W-1:0]    idx,
    output logic [NARROW_W-1:0] slice_out,
    output logic [WIDE_W-1:0]   merged_out
);
    localparam int RATIO = WIDE_W / NARROW_W;

    logic [RATIO-1:0]    slice_hit;
    logic [NARROW_W-1:0] masked [RATIO];

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_slice
            // Transfer index at which physical slice gi is visited.
            localparam int ORDER = (MSB_FIRST != 0) ? (RATIO - 1 - gi) : gi;
            assign slice_hit[gi] = (idx == IDX_W'(ORDER));
            assign masked[gi]    = slice_hit[gi] ? wide_in[gi*NARROW_W +: NARROW_W] : '0;
            assign merged_out[gi*NARROW_W +: NARROW_W] =
                slice_hit[gi] ? narrow_in : wide_in[gi*NARROW_W +: NARROW_W];
        end
    endgenerate

    always_comb begin
        slice_out = '0;
        for (int i = 0; i < RATIO; i++)
            slice_out = slice_out | masked[i];
    end

endmodule

// File: rtl/stream_width_converter.sv
// Valid/ready stream width converter: pass-through, down- or up-conversion.
// Define SWC_LAST_EN to add in_last/out_last burst framing.
module stream_width_converter
    import stream_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef SWC_LAST_EN
    ,
    input  logic             in_last,
    output logic             out_last
`endif
);
    localparam int RATIO = swc_ratio(IN_W, OUT_W);
    localparam int IDX_W = swc_idx_w(RATIO);
    localparam int MODE  = swc_mode(IN_W, OUT_W);

    generate
        if ((IN_W % OUT_W) != 0 && (OUT_W % IN_W) != 0) begin : g_bad_ratio
            $error("stream_width_converter: IN_W and OUT_W must be integer multiples");
        end

        if (MODE == SWC_PASS) begin : g_pass
            logic [OUT_W-1:0] data_reg;
            logic             valid_reg;

            assign in_ready  = !rst && (!valid_reg || out_ready);
            assign out_data  = data_reg;
            assign out_valid = valid_reg;
            assign busy      = valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (in_valid && in_ready) begin
                    data_reg  <= in_data;
                    valid_reg <= 1'b1;
                end else if (out_ready) begin
                    valid_reg <= 1'b0;
                end
            end
`ifdef SWC_LAST_EN
            logic last_reg;
            assign out_last = last_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    last_reg <= 1'b0;
                else if (in_valid && in_ready)
                    last_reg <= in_last;
            end
`endif
        end else if (MODE == SWC_DOWN) begin : g_down
            swc_state_t       state_reg, state_next;
            logic [IN_W-1:0]  hold_reg, hold_next;
            logic [IDX_W-1:0] idx_reg, idx_next;
            logic             in_ready_w;
            logic             at_last_slice;
            logic [IN_W-1:0]  unused_merged;

            assign at_last_slice = (idx_reg == IDX_W'(RATIO - 1));
            assign in_ready      = !rst && in_ready_w;
            assign out_valid     = (state_reg == SWC_SHIFT);
            assign busy          = out_valid;

            swc_slice_mux #(
                .WIDE_W    (IN_W),
                .NARROW_W  (OUT_W),
                .MSB_FIRST (MSB_FIRST),
                .IDX_W     (IDX_W)
            ) u_slice_mux (
                .wide_in    (hold_reg),
                .narrow_in  ('0),
                .idx        (idx_reg),
                .slice_out  (out_data),
                .merged_out (unused_merged)
            );

            always_comb begin
                state_next = state_reg;
                hold_next  = hold_reg;
                idx_next   = idx_reg;
                in_ready_w = 1'b0;
                case (state_reg)
                    SWC_IDLE: begin
                        in_ready_w = 1'b1;
                        if (in_valid) begin
                            hold_next  = in_data;
                            idx_next   = '0;
                            state_next = SWC_SHIFT;
                        end
                    end
                    SWC_SHIFT: begin
                        if (out_ready) begin
                            if (!at_last_slice) begin
                                idx_next = idx_reg + 1'b1;
                            end else begin
                                // Final slice leaving: take the next word in the same cycle.
                                in_ready_w = 1'b1;
                                idx_next   = '0;
                                if (in_valid)
                                    hold_next = in_data;
                                else
                                    state_next = SWC_IDLE;
                            end
                        end
                    end
                    default: state_next = SWC_IDLE;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= SWC_IDLE;
                    hold_reg  <= '0;
                    idx_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    hold_reg  <= hold_next;
                    idx_reg   <= idx_next;
                end
            end
`ifdef SWC_LAST_EN
            logic last_hold_reg;
            assign out_last = out_valid && last_hold_reg && at_last_slice;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    last_hold_reg <= 1'b0;
                else if (in_valid && in_ready)
                    last_hold_reg <= in_last;
            end
`endif
        end else begin : g_up
            logic [OUT_W-1:0] acc_reg;
            logic [OUT_W-1:0] acc_merged;
            logic [OUT_W-1:0] data_reg;
            logic             valid_reg;
            logic [IDX_W-1:0] idx_reg;
            logic             word_done;
            logic             in_fire;
            logic [IN_W-1:0]  unused_slice;

`ifdef SWC_LAST_EN
            // A flushing in_last also needs the output register free.
            assign word_done = (idx_reg == IDX_W'(RATIO - 1)) || in_last;
`else
            assign word_done = (idx_reg == IDX_W'(RATIO - 1));
`endif
            assign in_ready  = !rst && !(word_done && valid_reg && !out_ready);
            assign in_fire   = in_valid && in_ready;
            assign out_data  = data_reg;
            assign out_valid = valid_reg;
            assign busy      = valid_reg || (idx_reg != '0);

            swc_slice_mux #(
                .WIDE_W    (OUT_W),
                .NARROW_W  (IN_W),
                .MSB_FIRST (MSB_FIRST),
                .IDX_W     (IDX_W)
            ) u_slice_mux (
                .wide_in    (acc_reg),
                .narrow_in  (in_data),
                .idx        (idx_reg),
                .slice_out  (unused_slice),
                .merged_out (acc_merged)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg   <= '0;
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    idx_reg   <= '0;
                end else begin
                    if (out_ready)
                        valid_reg <= 1'b0;
                    if (in_fire) begin
                        if (word_done) begin
                            // Clearing the accumulator zero-fills the next (possibly flushed) word.
                            data_reg  <= acc_merged;
                            valid_reg <= 1'b1;
                            acc_reg   <= '0;
                            idx_reg   <= '0;
                        end else begin
                            acc_reg <= acc_merged;
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
            end
`ifdef SWC_LAST_EN
            logic last_reg;
            assign out_last = last_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    last_reg <= 1'b0;
                else if (in_fire && word_done)
                    last_reg <= in_last;
            end
`endif
        end
    endgenerate

endmodule
